// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor.
//   state_e    : controller states (IDLE, RUN, DONE)
//   num_chunks : number of CHUNK-bit slices in a WIDTH-bit operand
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/serial_subtractor_64_sub_chunk.sv
// Combinational CHUNK-bit borrow-ripple subtractor: {bo, diff} = x - y - bi.
// Ports:
//   x    : minuend slice
//   y    : subtrahend slice
//   bi   : borrow in
//   diff : difference slice
//   bo   : borrow out
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] diff,
    output logic             bo
);

    // brw[i] is the borrow flowing into bit i.
    logic [CHUNK:0] brw;

    always_comb begin
        brw    = '0;
        diff   = '0;
        brw[0] = bi;
        for (int i = 0; i < CHUNK; i++) begin
            diff[i]    = x[i] ^ y[i] ^ brw[i];
            // Borrow out when y[i]+borrow exceeds x[i].
            brw[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw[i]);
        end
        bo = brw[CHUNK];
    end

endmodule

// File: rtl/serial_subtractor_64.sv
// Multi-cycle subtractor: d = a - b - bin, CHUNK bits per clock, LSB first.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE, and
// the result stays stable until out_ready is seen there.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (d, borrow, ovf)
//   d                    : difference mod 2^WIDTH
//   borrow               : 1 iff unsigned a < b + bin
//   ovf                  : (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])
//   dbg_state            : current controller state
module serial_subtractor_64
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf,
    output state_e           dbg_state
);

    localparam int N   = num_chunks(WIDTH, CHUNK);
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
        $error("CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             brw_q, brw_d;
    // Partial result builds here; d only changes when a full result is ready,
    // so no partially computed value is ever visible on d.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] x_slice, y_slice, diff;
    logic             bo;

    assign x_slice = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    assign y_slice = b_q[int'(cnt_q) * CHUNK +: CHUNK];

    sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .x    (x_slice),
        .y    (y_slice),
        .bi   (brw_q),
        .diff (diff),
        .bo   (bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            acc_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brw_q    <= brw_d;
            acc_q    <= acc_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        acc_d    = acc_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[int'(cnt_q) * CHUNK +: CHUNK] = diff;
                brw_d = bo;
                if (cnt_q == LAST) begin
                    // Counter parks at 0 instead of running past N-1.
                    cnt_d    = '0;
                    state_d  = DONE;
                    d_d      = acc_d;
                    borrow_d = bo;
                    ovf_d    = (a_q[MSB] != b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_64.sv
module tb_serial_subtractor_64;
    import serial_subtractor_pkg::*;

    localparam int W = 64;
    localparam int N = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  d;
    logic          borrow;
    logic          ovf;
    state_e        dbg_state;

    serial_subtractor_64 #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    // Packed expectation: {ovf, borrow, d}
    logic [W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        logic [W-1:0] dd;
        logic         bw;
        logic         ov;
        dd = ma - mb - W'(mbin);
        bw = ({1'b0, ma} < ({1'b0, mb} + (W+1)'(mbin)));
        ov = (ma[W-1] != mb[W-1]) && (dd[W-1] != ma[W-1]);
        return {ov, bw, dd};
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 15));
            default: return rand64();
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_d",         d,             W'(0));
        check("rst_borrow",    W'(borrow),    W'(0));
        check("rst_ovf",       W'(ovf),       W'(0));
        rst_n = 1'b1;
    endtask

    // One full operation; hold = cycles of out_ready=0 in DONE while
    // in_valid is driven with unrelated operands.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input int hold);
        logic [W+1:0] e;
        int           edges;
        logic         leak;
        @(negedge clk);
        check("accept_ready", W'(in_ready), W'(1));
        a         = ta;
        b         = tb;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(model(ta, tb, tbin));
        @(posedge clk);
        #1;
        // Scramble the inputs: only the accept edge may matter.
        in_valid = 1'b0;
        a        = rand64();
        b        = rand64();
        bin      = 1'($urandom_range(0, 1));
        // The accept edge itself counts as edge 1.
        edges = 1;
        leak  = 1'b0;
        @(negedge clk);
        while (!out_valid && edges < 3 * N) begin
            if (in_ready) leak = 1'b1;
            // Operands offered mid-run must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency_edges", W'(edges), W'(N + 1));
        check("ready_low_run", W'(leak),  W'(0));
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            a        = rand64();
            b        = rand64();
            bin      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            check("hold_d",         d,              e[W-1:0]);
            check("hold_borrow",    W'(borrow),     W'(e[W]));
            check("hold_in_ready",  W'(in_ready),   W'(0));
            check("hold_out_valid", W'(out_valid),  W'(1));
            @(negedge clk);
        end
        check("res_d",      d,          e[W-1:0]);
        check("res_borrow", W'(borrow), W'(e[W]));
        check("res_ovf",    W'(ovf),    W'(e[W+1]));
        // in_valid may stay high across the release edge: it must not be taken.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("post_out_valid", W'(out_valid), W'(0));
        check("post_in_ready",  W'(in_ready),  W'(1));
        check("post_d_kept",    d,             e[W-1:0]);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        a        = rand64();
        b        = rand64();
        bin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Accept edge + 7 edges: chunk 7 is being processed.
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_in_ready",  W'(in_ready),  W'(1));
        check("abort_d",         d,             W'(0));
        check("abort_borrow",    W'(borrow),    W'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        run_op('0, '0, 1'b0, 0);
        run_op(W'(1), W'(1), 1'b1, 0);
        run_op(W'(64'hC), W'(64'h6), 1'b1, 1);
        run_op(64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, W'(1), 1'b0, 2);
        run_op('0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op(rand64(), rand64(), 1'b1, 5);
        run_op(rand64(), rand64(), 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end
        run_op(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 0);
        reset_mid_run();
        run_op(W'(5), W'(3), 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/serial_subtractor_64.md
Name: serial_subtractor_64

Overview:
Multi-cycle 64-bit subtractor: computes d = a - b - bin, CHUNK bits per clock, LSB chunk first, with a borrow chained between chunks. It is the inverse-direction companion of the team's combinational 64-bit full adder and shares its operand and carry conventions. It sits behind a valid/ready handshake, so upstream and downstream logic can stall it.

Parameters:
WIDTH, 64, operand/result width in bits
CHUNK, 4, bits processed per cycle; must divide WIDTH (elaboration error otherwise)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, bin are valid this cycle
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in (subtracted as one more LSB)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
d  output  WIDTH  difference, mod 2^WIDTH
borrow  output  1  1 iff unsigned a < b + bin
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; d=0; borrow=0; ovf=0; chunk counter=0; operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: register a, b, bin; borrow register <= bin; counter <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, chunk k = counter: {bout, diff} = a[k] - b[k] - borrow_reg, computed by a CHUNK-bit borrow ripple.
  - diff is written into d slice k; borrow_reg <= bout; counter++.
  - After chunk N-1 (N = WIDTH/CHUNK; 16 at defaults): go to DONE; borrow <= final bout; ovf computed from the registered operand MSBs and d[MSB].
- DONE:
  - out_valid=1, in_ready=0.
  - d, borrow, ovf are held stable while out_ready=0.
  - On out_ready: out_valid deasserts next cycle and state returns to IDLE. d, borrow, ovf keep their last values until the next DONE.
- Latency: out_valid rises exactly N+1 clock edges after the accepting edge (17 at defaults). Throughput: one operation per N+2 cycles minimum.
- in_valid while not in IDLE is ignored; no operand capture and no error. The input side never accepts during DONE, even when out_ready=1 in the same cycle.
- Input operands are sampled only at the accept edge; later changes on a, b, bin have no effect.
- Wrap-around: result is mod 2^WIDTH; e.g. 0 - 0 - 1 gives all-ones with borrow=1.
- Reset mid-RUN or mid-DONE aborts the operation immediately; outputs go to reset values; no partial result is ever presented.
- Counter width: clog2(N), minimum 1 bit; no overflow beyond N-1.

Decomposition:
- Package serial_subtractor_pkg: state enum (IDLE, RUN, DONE) and function num_chunks(WIDTH, CHUNK).
- Sub-module sub_chunk: combinational, parameter CHUNK. Ports x, y, bi -> diff, bo. Implements {bo, diff} = x - y - bi as a ripple of full-subtractor bits.
- Top module holds the FSM, counter, operand registers and output registers.

Test Plan:
1. a=0, b=0, bin=0 -> d=0, borrow=0, ovf=0; out_valid exactly 17 edges after accept; in_ready low throughout.
2. a=1, b=1, bin=1 -> d=64'hFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0.
3. a=64'hC, b=64'h6, bin=1 -> d=5, borrow=0; a=64'hFFFF_FFFF_FFFF_FFF6, b=64'hFFFF_FFFF_FFFF_FFF1, bin=1 -> d=4, borrow=0.
4. a=64'h8000_0000_0000_0000, b=1, bin=0 -> d=64'h7FFF_FFFF_FFFF_FFFF, borrow=0, ovf=1; a=0, b=64'hFFFF_FFFF_FFFF_FFFF, bin=0 -> d=1, borrow=1, ovf=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> d/borrow/ovf stable, in_ready=0, new operands not captured; on out_ready=1, return to IDLE, then the next op computes correctly.
6. Assert rst_n=0 at chunk 7 of RUN -> out_valid=0, d=0, in_ready=1 immediately; after release, a fresh op (a=5, b=3, bin=0) -> d=2, borrow=0.
